// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (adds the TRAP state).
package fetch_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0] word_t;

  localparam word_t PC_STEP          = 32'd4;
  localparam word_t DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_VALID
`ifdef FETCH_MISALIGN_TRAP_EN
    , ST_TRAP
`endif
  } state_t;

  function automatic logic is_misaligned(input word_t addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Request/grant/response instruction-memory port; the fetch unit is the master.
interface fetch_imem_if;
  import fetch_pkg::*;

  logic  req;
  word_t addr;
  logic  gnt;
  logic  rvalid;
  word_t rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);

endinterface

// File: rtl/fetch_unit_next_pc_sel.sv
// Next-PC priority mux: jump over branch over sequential, with alignment handling.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (raw target passed through).
module next_pc_sel
  import fetch_pkg::*;
(
  input  logic  i_jump,
  input  word_t i_jump_target,
  input  logic  i_branch,
  input  word_t i_branch_target,
  input  word_t i_instr_pc,
  output word_t o_next_pc
);

  word_t w_raw_pc;

  always_comb begin
    if (i_jump) begin
      w_raw_pc = i_jump_target;
    end else if (i_branch) begin
      w_raw_pc = i_branch_target;
    end else begin
      w_raw_pc = i_instr_pc + PC_STEP;  // wraps modulo 2^32
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  // The offending address must survive so the trap can report it.
  assign o_next_pc = w_raw_pc;
`else
  assign o_next_pc = w_raw_pc & ~word_t'(3);
`endif

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: owns the PC, runs one imem request at a time.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (sticky AlignErr + TRAP state).
module fetch_unit
  import fetch_pkg::*;
#(
  parameter word_t RESET_PC = DEFAULT_RESET_PC
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          PCSrc,
  input  word_t         BranchTarget,
  input  logic          Jump,
  input  word_t         JumpTarget,
  input  logic          Stall,
  fetch_imem_if.master  imem,
  output word_t         Instr,
  output word_t         InstrPC,
  output logic          InstrValid,
  output word_t         PC,
  output logic          AlignErr
);

  state_t r_state;
  state_t w_state_next;
  word_t  r_pc;
  word_t  r_instr;
  word_t  r_instr_pc;
  word_t  w_next_pc;
  logic   w_load_pc;
  logic   w_load_instr;

  next_pc_sel u_next_pc_sel (
    .i_jump          (Jump),
    .i_jump_target   (JumpTarget),
    .i_branch        (PCSrc),
    .i_branch_target (BranchTarget),
    .i_instr_pc      (r_instr_pc),
    .o_next_pc       (w_next_pc)
  );

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_load_pc    = 1'b0;
    w_load_instr = 1'b0;
    case (r_state)
      ST_IDLE:  w_state_next = ST_REQ;
      ST_REQ:   if (imem.gnt) w_state_next = ST_WAIT;
      ST_WAIT: begin
        if (imem.rvalid) begin
          w_load_instr = 1'b1;
          w_state_next = ST_VALID;
        end
      end
      ST_VALID: begin
        if (!Stall) begin
          w_load_pc    = 1'b1;
          w_state_next = ST_REQ;
`ifdef FETCH_MISALIGN_TRAP_EN
          if (is_misaligned(w_next_pc)) w_state_next = ST_TRAP;
`endif
        end
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      ST_TRAP:  w_state_next = ST_TRAP;
`endif
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_instr    <= '0;
      r_instr_pc <= RESET_PC;
    end else begin
      if (w_load_pc) r_pc <= w_next_pc;
      if (w_load_instr) begin
        r_instr    <= imem.rdata;
        r_instr_pc <= r_pc;
      end
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  logic r_align_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_align_err <= 1'b0;
    end else if (w_load_pc && is_misaligned(w_next_pc)) begin
      r_align_err <= 1'b1;
    end
  end

  assign AlignErr = r_align_err;
`else
  assign AlignErr = 1'b0;
`endif

  // Address comes straight from the PC register, so it is stable until granted.
  assign imem.req   = (r_state == ST_REQ);
  assign imem.addr  = r_pc;
  assign Instr      = r_instr;
  assign InstrPC    = r_instr_pc;
  assign InstrValid = (r_state == ST_VALID);
  assign PC         = r_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit, macro-aware for FETCH_MISALIGN_TRAP_EN.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic  clk;
  logic  rst_n;
  logic  PCSrc;
  word_t BranchTarget;
  logic  Jump;
  word_t JumpTarget;
  logic  Stall;
  word_t Instr;
  word_t InstrPC;
  logic  InstrValid;
  word_t PC;
  logic  AlignErr;

  int checks   = 0;
  int failures = 0;

  fetch_imem_if imem_bus ();

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .PCSrc        (PCSrc),
    .BranchTarget (BranchTarget),
    .Jump         (Jump),
    .JumpTarget   (JumpTarget),
    .Stall        (Stall),
    .imem         (imem_bus),
    .Instr        (Instr),
    .InstrPC      (InstrPC),
    .InstrValid   (InstrValid),
    .PC           (PC),
    .AlignErr     (AlignErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // From REQ: grant now, respond next cycle, land in VALID.
  task automatic do_fetch(input word_t data);
    imem_bus.gnt = 1'b1;
    step();
    imem_bus.gnt    = 1'b0;
    imem_bus.rvalid = 1'b1;
    imem_bus.rdata  = data;
    step();
    imem_bus.rvalid = 1'b0;
    imem_bus.rdata  = '0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req"},   32'(imem_bus.req), 32'd0);
    check({tag, "_addr"},  imem_bus.addr, 32'h0);
    check({tag, "_pc"},    PC, 32'h0);
    check({tag, "_ipc"},   InstrPC, 32'h0);
    check({tag, "_instr"}, Instr, 32'h0);
    check({tag, "_valid"}, 32'(InstrValid), 32'd0);
    check({tag, "_align"}, 32'(AlignErr), 32'd0);
  endtask

  initial begin
    rst_n           = 1'b0;
    PCSrc           = 1'b0;
    BranchTarget    = '0;
    Jump            = 1'b0;
    JumpTarget      = '0;
    Stall           = 1'b0;
    imem_bus.gnt    = 1'b0;
    imem_bus.rvalid = 1'b0;
    imem_bus.rdata  = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("rst");

    // Cycle 0 IDLE, cycle 1 REQ+gnt, cycle 2 WAIT+rvalid, cycle 3 VALID.
    imem_bus.gnt = 1'b1;
    rst_n = 1'b1;
    check("idle_req", 32'(imem_bus.req), 32'd0);
    step();
    check("c1_req", 32'(imem_bus.req), 32'd1);
    check("c1_addr", imem_bus.addr, 32'h0);
    step();
    check("c2_req", 32'(imem_bus.req), 32'd0);
    check("c2_valid", 32'(InstrValid), 32'd0);
    imem_bus.gnt    = 1'b0;
    imem_bus.rvalid = 1'b1;
    imem_bus.rdata  = 32'h0010_0093;
    step();
    imem_bus.rvalid = 1'b0;
    check("c3_valid", 32'(InstrValid), 32'd1);
    check("c3_ipc", InstrPC, 32'h0);
    check("c3_instr", Instr, 32'h0010_0093);

    step();
    check("seq_req", 32'(imem_bus.req), 32'd1);
    check("seq_addr", imem_bus.addr, 32'h4);
    check("seq_valid", 32'(InstrValid), 32'd0);
    check("seq_instr_hold", Instr, 32'h0010_0093);

    // Ungranted REQ holds its address; stray rvalid there is ignored.
    imem_bus.rvalid = 1'b1;
    imem_bus.rdata  = 32'hDEAD_BEEF;
    step();
    imem_bus.rvalid = 1'b0;
    check("hold_req", 32'(imem_bus.req), 32'd1);
    check("hold_addr", imem_bus.addr, 32'h4);
    check("stale_instr", Instr, 32'h0010_0093);
    do_fetch(32'h0020_0113);
    check("f4_ipc", InstrPC, 32'h4);
    check("f4_instr", Instr, 32'h0020_0113);

    Jump = 1'b1;
    JumpTarget = 32'h100;
    step();
    Jump = 1'b0;
    check("jmp_addr", imem_bus.addr, 32'h100);
    do_fetch(32'h0000_0101);
    check("f100_ipc", InstrPC, 32'h100);

    PCSrc = 1'b1;
    BranchTarget = 32'h200;
    step();
    PCSrc = 1'b0;
    check("br_addr", imem_bus.addr, 32'h200);
    do_fetch(32'h0000_0201);
    check("f200_ipc", InstrPC, 32'h200);

    PCSrc = 1'b1;
    Jump = 1'b1;
    JumpTarget = 32'h300;
    BranchTarget = 32'h200;
    step();
    PCSrc = 1'b0;
    Jump = 1'b0;
    check("jmp_over_br", imem_bus.addr, 32'h300);
    do_fetch(32'h0000_0301);
    check("f300_ipc", InstrPC, 32'h300);

    // Five stalled cycles with a mid-stall branch pulse that must be ignored.
    Stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      PCSrc = (i == 2);
      BranchTarget = 32'h500;
      step();
      check($sformatf("stall%0d_req", i), 32'(imem_bus.req), 32'd0);
      check($sformatf("stall%0d_valid", i), 32'(InstrValid), 32'd1);
      check($sformatf("stall%0d_ipc", i), InstrPC, 32'h300);
      check($sformatf("stall%0d_pc", i), PC, 32'h300);
    end
    Stall = 1'b0;
    PCSrc = 1'b0;
    step();
    check("unstall_addr", imem_bus.addr, 32'h304);
    do_fetch(32'h0000_0305);

    Jump = 1'b1;
    JumpTarget = 32'hFFFF_FFFC;
    step();
    Jump = 1'b0;
    check("top_addr", imem_bus.addr, 32'hFFFF_FFFC);
    do_fetch(32'h0000_0FFC);
    check("top_ipc", InstrPC, 32'hFFFF_FFFC);
    step();
    check("wrap_addr", imem_bus.addr, 32'h0);
    check("wrap_pc", PC, 32'h0);

    // Redirects held through REQ and WAIT have no effect.
    Jump = 1'b1;
    JumpTarget = 32'h700;
    PCSrc = 1'b1;
    BranchTarget = 32'h600;
    imem_bus.gnt = 1'b1;
    step();
    imem_bus.gnt = 1'b0;
    check("nored_pc", PC, 32'h0);
    imem_bus.rvalid = 1'b1;
    imem_bus.rdata  = 32'h0000_0A0A;
    step();
    imem_bus.rvalid = 1'b0;
    Jump = 1'b0;
    PCSrc = 1'b0;
    check("nored_ipc", InstrPC, 32'h0);
    check("nored_valid", 32'(InstrValid), 32'd1);

    PCSrc = 1'b1;
    BranchTarget = 32'h202;
    step();
    PCSrc = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    check("trap_align", 32'(AlignErr), 32'd1);
    check("trap_req", 32'(imem_bus.req), 32'd0);
    check("trap_pc", PC, 32'h202);
    check("trap_valid", 32'(InstrValid), 32'd0);
    imem_bus.gnt = 1'b1;
    repeat (3) step();
    imem_bus.gnt = 1'b0;
    check("trap_stay_req", 32'(imem_bus.req), 32'd0);
    check("trap_stay_align", 32'(AlignErr), 32'd1);
`else
    check("mis_addr", imem_bus.addr, 32'h200);
    check("mis_req", 32'(imem_bus.req), 32'd1);
    check("mis_align", 32'(AlignErr), 32'd0);
    imem_bus.gnt = 1'b1;
    step();
    imem_bus.gnt = 1'b0;
    check("wait_req", 32'(imem_bus.req), 32'd0);
`endif

    // Asynchronous reset mid-flight; the late response lands in IDLE.
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    @(posedge clk);
    #1;
    imem_bus.rvalid = 1'b1;
    imem_bus.rdata  = 32'hBAD0_BAD0;
    rst_n = 1'b1;
    step();
    imem_bus.rvalid = 1'b0;
    imem_bus.rdata  = '0;
    check("drop_instr", Instr, 32'h0);
    check("drop_valid", 32'(InstrValid), 32'd0);
    check("refetch_req", 32'(imem_bus.req), 32'd1);
    check("refetch_addr", imem_bus.addr, 32'h0);
    do_fetch(32'h0000_1111);
    check("refetch_ipc", InstrPC, 32'h0);
    check("refetch_instr", Instr, 32'h0000_1111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
